pe_output_serializer: RTL

- Downstream stage of the neuron PE array.
- Captures one frame: the quantized pe_out of all NUM_PE PEs, taken when the layer controller pulses capture after accumulation completes.
- Streams the frame element-by-element, PE 0 first, as the next layer's input_data/input_available stream with a valid/ready handshake.
- Two-frame ping-pong buffering lets layer N+1 consume frame k while layer N produces frame k+1.

---
 rtl/pe_pkg.sv | 27 ++
 rtl/pe_frame_slot.sv | 44 ++++
 rtl/pe_output_serializer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared types and helpers for the PE output serializer.
// The zero-skip helper is only used when PE_OUTPUT_ZERO_SKIP_EN is defined.
package pe_pkg;

  typedef enum logic [0:0] {IDLE, STREAM} ser_state_t;

  localparam int unsigned NUM_FRAMES = 2;

  // Upper bound on NUM_PE accepted by next_nonzero.
  localparam int unsigned MAX_PE = 64;

  // First set bit of mask strictly above 'from' and below 'num'; returns num if none.
  function automatic int unsigned next_nonzero(input logic [MAX_PE-1:0] mask,
                                               input int unsigned       from,
                                               input int unsigned       num);
    logic found;
    found        = 1'b0;
    next_nonzero = num;
    for (int unsigned i = 0; i < MAX_PE; i++) begin
      if (!found && i > from && i < num && mask[i]) begin
        next_nonzero = i;
        found        = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/pe_frame_slot.sv
// One frame buffer: loads all NUM_PE elements at once, reads one by index.
// With PE_OUTPUT_ZERO_SKIP_EN it also keeps a per-element nonzero mask.
module pe_frame_slot #(
  parameter int unsigned NUM_PE       = 4,
  parameter int unsigned PE_OUT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load,
  input  logic [NUM_PE*PE_OUT_WIDTH-1:0] frame_in,
  input  logic [$clog2(NUM_PE)-1:0]      idx,
`ifdef PE_OUTPUT_ZERO_SKIP_EN
  output logic [NUM_PE-1:0]              nz_mask,
`endif
  output logic [PE_OUT_WIDTH-1:0]        elem
);

  logic [PE_OUT_WIDTH-1:0] data_q [NUM_PE];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PE; i++) data_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_PE; i++) data_q[i] <= frame_in[i*PE_OUT_WIDTH +: PE_OUT_WIDTH];
    end
  end

  assign elem = data_q[idx];

`ifdef PE_OUTPUT_ZERO_SKIP_EN
  logic [NUM_PE-1:0] mask_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_PE; i++) mask_q[i] <= |frame_in[i*PE_OUT_WIDTH +: PE_OUT_WIDTH];
    end
  end

  assign nz_mask = mask_q;
`endif

endmodule

// File: rtl/pe_output_serializer.sv
// Ping-pong frame buffer that streams captured PE outputs one element per beat.
// Optional zero skipping and out_index port under PE_OUTPUT_ZERO_SKIP_EN.
module pe_output_serializer
  import pe_pkg::*;
#(
  parameter int unsigned NUM_PE       = 4,
  parameter int unsigned PE_OUT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           capture,
  input  logic [NUM_PE*PE_OUT_WIDTH-1:0] pe_out_bus,
  output logic                           capture_ready,
  output logic [PE_OUT_WIDTH-1:0]        out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
`ifdef PE_OUTPUT_ZERO_SKIP_EN
  output logic [$clog2(NUM_PE)-1:0]      out_index,
`endif
  output logic                           overflow
);

  localparam int unsigned IDX_WIDTH = $clog2(NUM_PE);

  ser_state_t             state_q, state_d;
  logic [1:0]             frame_count_q, frame_count_d;
  logic                   wr_slot_q, wr_slot_d;
  logic                   rd_slot_q, rd_slot_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic                   overflow_q, overflow_d;

  logic                   cap_ok, streaming, cur_nz, has_next, advance, pop;
  logic [IDX_WIDTH-1:0]   next_idx;
  logic [PE_OUT_WIDTH-1:0] slot_elem [NUM_FRAMES];
  logic [PE_OUT_WIDTH-1:0] rd_elem;
`ifdef PE_OUTPUT_ZERO_SKIP_EN
  logic [NUM_PE-1:0]      slot_mask [NUM_FRAMES];
  logic [NUM_PE-1:0]      rd_mask;
  int unsigned            nxt;
`endif

  for (genvar s = 0; s < NUM_FRAMES; s++) begin : g_slot
    pe_frame_slot #(
      .NUM_PE       (NUM_PE),
      .PE_OUT_WIDTH (PE_OUT_WIDTH)
    ) u_slot (
      .clk      (clk),
      .reset    (reset),
      .load     (cap_ok && (wr_slot_q == 1'(s))),
      .frame_in (pe_out_bus),
      .idx      (idx_q),
`ifdef PE_OUTPUT_ZERO_SKIP_EN
      .nz_mask  (slot_mask[s]),
`endif
      .elem     (slot_elem[s])
    );
  end

  always_comb begin
    capture_ready = (frame_count_q < 2'(NUM_FRAMES));
    cap_ok        = capture && capture_ready;
    rd_elem       = slot_elem[rd_slot_q];
    streaming     = (state_q == STREAM);

`ifdef PE_OUTPUT_ZERO_SKIP_EN
    rd_mask  = slot_mask[rd_slot_q];
    cur_nz   = rd_mask[idx_q];
    nxt      = next_nonzero(MAX_PE'(rd_mask), 32'(idx_q), NUM_PE);
    has_next = (nxt < NUM_PE);
    next_idx = IDX_WIDTH'(nxt);
`else
    cur_nz   = 1'b1;
    has_next = (idx_q != IDX_WIDTH'(NUM_PE - 1));
    next_idx = idx_q + 1'b1;
`endif

    out_valid = streaming && cur_nz;
    out_last  = out_valid && !has_next;
    out_data  = out_valid ? rd_elem : '0;

    // Zero elements are stepped over without waiting for the consumer.
    advance = streaming && (!cur_nz || out_ready);
    pop     = advance && !has_next;

    frame_count_d = frame_count_q + {1'b0, cap_ok} - {1'b0, pop};
    wr_slot_d     = wr_slot_q ^ cap_ok;
    rd_slot_d     = rd_slot_q ^ pop;
    overflow_d    = overflow_q | (capture && !capture_ready);

    idx_d = idx_q;
    if (advance) idx_d = has_next ? next_idx : '0;

    // Looking at frame_count_d lets a fresh capture start streaming on the next cycle
    // and lets a frame captured alongside a pop follow without a bubble.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (frame_count_d != 2'd0) state_d = STREAM;
      STREAM:  if (pop && frame_count_d == 2'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      frame_count_q <= '0;
      wr_slot_q     <= 1'b0;
      rd_slot_q     <= 1'b0;
      idx_q         <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_count_q <= frame_count_d;
      wr_slot_q     <= wr_slot_d;
      rd_slot_q     <= rd_slot_d;
      idx_q         <= idx_d;
      overflow_q    <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`ifdef PE_OUTPUT_ZERO_SKIP_EN
  assign out_index = idx_q;
`endif

endmodule
